// File: rtl/enemy_fire_sched.sv
// rtl/enemy_fire_sched.sv - enemy missile fire scheduler (optional LFSR start: ENEMY_FIRE_SCHED_RANDOM_EN)
module enemy_fire_sched #(
    parameter int FRAMES_BASE    = 60,
    parameter int FRAMES_STEP    = 4,
    parameter int FRAMES_MIN     = 8,
    parameter int MAX_INFLIGHT   = 3,
    parameter int HOLDOFF_FRAMES = 120
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic [4:0] alive,
    input  logic [4:0] busy,
    input  logic [3:0] level_in,
    input  logic       level_change,
    output logic [4:0] fire,
    output logic [2:0] fire_id,
    output logic [2:0] inflight,
    output logic       holdoff
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SEARCH  = 2'd1;
    localparam logic [1:0] S_GRANT   = 2'd2;
    localparam logic [1:0] S_HOLDOFF = 2'd3;

    localparam logic [15:0] BASE16    = 16'(FRAMES_BASE);
    localparam logic [7:0]  MIN8      = 8'(FRAMES_MIN);
    localparam logic [2:0]  MAX3      = 3'(MAX_INFLIGHT);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLDOFF_FRAMES - 1);

    logic       vsync_q, vsync_d1_q, armed_q, tick_q;
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] tries_q, tries_d;
    logic [2:0] inflight_q, inflight_d;

    logic [3:0]  lvl_eff;
    logic [15:0] step_total;
    logic [7:0]  interval_raw, interval;
    logic [2:0]  ptr_inc;
    logic        eligible;

`ifdef ENEMY_FIRE_SCHED_RANDOM_EN
    logic [4:0] lfsr_q;
    logic [2:0] lfsr_mod5;

    // Free-running 5-bit Fibonacci LFSR (taps 5,3) seeding the search start
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) lfsr_q <= 5'b10101;
        else     lfsr_q <= {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    end

    assign lfsr_mod5 = 3'(lfsr_q % 5'd5);
`endif

    // Frame tick: edge on the registered vsync; the first cycle after reset
    // primes the history with the live input so an already-high vsync is no edge
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_q    <= 1'b0;
            vsync_d1_q <= 1'b0;
            armed_q    <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            vsync_q    <= vsync_in;
            vsync_d1_q <= armed_q ? vsync_q : vsync_in;
            armed_q    <= 1'b1;
            tick_q     <= vsync_q & ~vsync_d1_q;
        end
    end

    // Shot interval from level, saturated at 0 then floored at FRAMES_MIN
    always_comb begin
        lvl_eff      = (level_in == 4'd0) ? 4'd1 : level_in;
        step_total   = 16'(FRAMES_STEP) * {12'd0, lvl_eff - 4'd1};
        interval_raw = (step_total >= BASE16) ? 8'd0 : 8'(BASE16 - step_total);
        interval     = (interval_raw < MIN8) ? MIN8 : interval_raw;
    end

    // Popcount of busy, registered below so eligibility sees a stable value
    always_comb begin
        inflight_d = {2'b00, busy[0]} + {2'b00, busy[1]} + {2'b00, busy[2]}
                   + {2'b00, busy[3]} + {2'b00, busy[4]};
    end

    assign ptr_inc  = (ptr_q == 3'd4) ? 3'd0 : ptr_q + 3'd1;
    assign eligible = alive[ptr_q] & ~busy[ptr_q] & (inflight_q < MAX3);

    // Next-state logic; a level change overrides everything, including a grant
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        tries_d = tries_q;
        if (level_change) begin
            state_d = S_HOLDOFF;
            cnt_d   = 8'd0;
            ptr_d   = 3'd0;
            tries_d = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tick_q) begin
                        if (cnt_q >= interval - 8'd1) begin
                            state_d = S_SEARCH;
                            cnt_d   = 8'd0;
                            tries_d = 3'd0;
`ifdef ENEMY_FIRE_SCHED_RANDOM_EN
                            ptr_d   = lfsr_mod5;
`endif
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                S_SEARCH: begin
                    if (eligible) begin
                        state_d = S_GRANT;
                    end else begin
                        ptr_d = ptr_inc;
                        if (tries_q == 3'd4) begin
                            state_d = S_IDLE;
                            cnt_d   = 8'd0;
                        end else begin
                            tries_d = tries_q + 3'd1;
                        end
                    end
                end
                S_GRANT: begin
                    ptr_d   = ptr_inc;
                    state_d = S_IDLE;
                end
                S_HOLDOFF: begin
                    if (tick_q) begin
                        if (cnt_q >= HOLD_LAST) begin
                            state_d = S_IDLE;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Scheduler state registers
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            ptr_q      <= 3'd0;
            tries_q    <= 3'd0;
            inflight_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            tries_q    <= tries_d;
            inflight_q <= inflight_d;
        end
    end

    // Outputs decode straight from registers, so reset clears them at once
    always_comb begin
        fire    = 5'd0;
        fire_id = 3'd0;
        if (state_q == S_GRANT) begin
            fire    = 5'b00001 << ptr_q;
            fire_id = ptr_q + 3'd1;
        end
    end

    assign inflight = inflight_q;
    assign holdoff  = (state_q == S_HOLDOFF);

endmodule

// File: tb/tb_enemy_fire_sched.sv
// tb/tb_enemy_fire_sched.sv - self-checking bench for enemy_fire_sched
module tb_enemy_fire_sched;

    logic       pclk = 1'b0;
    logic       rst;
    logic       vsync_in;
    logic [4:0] alive;
    logic [4:0] busy;
    logic [3:0] level_in;
    logic       level_change;
    logic [4:0] fire;
    logic [2:0] fire_id;
    logic [2:0] inflight;
    logic       holdoff;

    enemy_fire_sched dut (
        .pclk        (pclk),
        .rst         (rst),
        .vsync_in    (vsync_in),
        .alive       (alive),
        .busy        (busy),
        .level_in    (level_in),
        .level_change(level_change),
        .fire        (fire),
        .fire_id     (fire_id),
        .inflight    (inflight),
        .holdoff     (holdoff)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [3:0] level;
        logic [4:0] alv;
        logic [4:0] bsy;
        int         max_ticks;
        int         exp_ticks;
        logic [4:0] exp_fire;
        logic [2:0] exp_id;
        logic [2:0] exp_inflight;
    } vec_t;

    vec_t tbl[12];
    int   nvec = 0;
    int   nerr = 0;

    int         got_t, nf, tcount;
    logic [4:0] got_f, pre_f;
    logic [2:0] got_id;
    logic       ho_low, found;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One vsync frame of 10 cycles (3 high); records any fire and any holdoff=0
    task automatic frame(output logic [4:0] f_seen, output logic [2:0] id_seen,
                         output int n_fire, output logic ho_lo);
        f_seen = 5'd0; id_seen = 3'd0; n_fire = 0; ho_lo = 1'b0;
        vsync_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (i == 2) vsync_in = 1'b0;
            if (!holdoff) ho_lo = 1'b1;
            if (fire != 5'd0) begin
                n_fire++;
                f_seen  = fire;
                id_seen = fire_id;
                chk("fire_onehot", $countones(fire), 1);
            end
        end
    endtask

    task automatic run_until_fire(input int max_t, output int t_found,
                                  output logic [4:0] f, output logic [2:0] id);
        logic [4:0] f1;
        logic [2:0] id1;
        int         n;
        logic       hl;
        t_found = 0; f = 5'd0; id = 3'd0;
        for (int t = 1; t <= max_t; t++) begin
            frame(f1, id1, n, hl);
            if (n > 0) begin
                t_found = t; f = f1; id = id1;
                break;
            end
        end
    endtask

    task automatic frames_nofire(input int n, output int fires, output logic ho_lo);
        logic [4:0] f1;
        logic [2:0] id1;
        int         k;
        logic       hl;
        fires = 0; ho_lo = 1'b0;
        for (int i = 0; i < n; i++) begin
            frame(f1, id1, k, hl);
            fires += k;
            if (hl) ho_lo = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            level  alive   busy    max exp  fire      id    infl
        tbl[0]  = '{4'd1,  5'h1F, 5'h00, 70, 60, 5'b00001, 3'd1, 3'd0};
        tbl[1]  = '{4'd1,  5'h1F, 5'h00, 70, 60, 5'b00010, 3'd2, 3'd0};
        tbl[2]  = '{4'd3,  5'h1F, 5'h00, 60, 52, 5'b00100, 3'd3, 3'd0};
        tbl[3]  = '{4'd15, 5'h1F, 5'h00, 12,  8, 5'b01000, 3'd4, 3'd0};
        tbl[4]  = '{4'd0,  5'h1F, 5'h00, 70, 60, 5'b10000, 3'd5, 3'd0};
        tbl[5]  = '{4'd15, 5'h14, 5'h00, 12,  8, 5'b00100, 3'd3, 3'd0};
        tbl[6]  = '{4'd15, 5'h14, 5'h00, 12,  8, 5'b10000, 3'd5, 3'd0};
        tbl[7]  = '{4'd15, 5'h1F, 5'h07, 16,  0, 5'b00000, 3'd0, 3'd3};
        tbl[8]  = '{4'd15, 5'h1F, 5'h03, 12,  8, 5'b00100, 3'd3, 3'd2};
        tbl[9]  = '{4'd13, 5'h1F, 5'h00, 16, 12, 5'b01000, 3'd4, 3'd0};
        tbl[10] = '{4'd2,  5'h1F, 5'h00, 64, 56, 5'b10000, 3'd5, 3'd0};
        tbl[11] = '{4'd15, 5'h00, 5'h00,  8,  0, 5'b00000, 3'd0, 3'd0};

        rst = 1'b1; vsync_in = 1'b0; alive = 5'h00; busy = 5'h1F;
        level_in = 4'd1; level_change = 1'b0;
        repeat (3) @(negedge pclk);
        chk("reset_fire", fire, 0);
        chk("reset_fire_id", fire_id, 0);
        chk("reset_inflight", inflight, 0);
        chk("reset_holdoff", holdoff, 0);
        busy = 5'h00; alive = 5'h1F;
        @(negedge pclk);
        rst = 1'b0;
        repeat (2) @(negedge pclk);

        for (int v = 0; v < 12; v++) begin
            level_in = tbl[v].level;
            alive    = tbl[v].alv;
            busy     = tbl[v].bsy;
            repeat (2) @(negedge pclk);
            chk($sformatf("vec%0d_inflight", v), inflight, tbl[v].exp_inflight);
            run_until_fire(tbl[v].max_ticks, got_t, got_f, got_id);
            chk($sformatf("vec%0d_ticks", v), got_t, tbl[v].exp_ticks);
            if (tbl[v].exp_ticks != 0) begin
                chk($sformatf("vec%0d_fire", v), got_f, tbl[v].exp_fire);
                chk($sformatf("vec%0d_fire_id", v), got_id, tbl[v].exp_id);
            end
        end

        // level_change exactly in the cycle a grant would start
        level_in = 4'd15; alive = 5'h1F; busy = 5'h00;
        repeat (2) @(negedge pclk);
        frames_nofire(7, nf, ho_low);
        chk("pre_holdoff_nofire", nf, 0);
        nf = 0;
        vsync_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (fire != 5'd0) nf++;
            if (i == 2) begin
                vsync_in = 1'b0;
                level_change = 1'b1;
            end
            if (i == 3) begin
                level_change = 1'b0;
                chk("holdoff_entered", holdoff, 1);
            end
        end
        chk("lc_blocks_grant", nf, 0);

        // 50 holdoff ticks, then a restart, then a full 120 ticks
        frames_nofire(50, nf, ho_low);
        chk("holdoff_held_50", ho_low, 0);
        chk("holdoff_nofire", nf, 0);
        level_change = 1'b1;
        @(negedge pclk);
        level_change = 1'b0;
        tcount = 0;
        for (int t = 1; t <= 130; t++) begin
            frame(got_f, got_id, nf, ho_low);
            if (ho_low) begin
                tcount = t;
                break;
            end
        end
        chk("holdoff_ticks", tcount, 120);
        run_until_fire(12, got_t, got_f, got_id);
        chk("post_holdoff_ticks", got_t, 8);
        chk("post_holdoff_fire", got_f, 5'b00001);
        chk("post_holdoff_id", got_id, 1);

        // asynchronous reset during a grant, released with vsync already high
        busy = 5'b00001;
        repeat (2) @(negedge pclk);
        chk("inflight_one", inflight, 1);
        frames_nofire(7, nf, ho_low);
        chk("pre_reset_nofire", nf, 0);
        found = 1'b0; pre_f = 5'd0;
        vsync_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge pclk);
            if (i == 2) vsync_in = 1'b0;
            if (fire != 5'd0 && !found) begin
                found = 1'b1;
                pre_f = fire;
                rst = 1'b1;
                #1;
                chk("async_rst_fire", fire, 0);
                chk("async_rst_fire_id", fire_id, 0);
                chk("async_rst_inflight", inflight, 0);
                chk("async_rst_holdoff", holdoff, 0);
            end
        end
        chk("grant_before_reset", found, 1);
        chk("grant_before_reset_fire", pre_f, 5'b00010);
        vsync_in = 1'b1;
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        repeat (3) @(negedge pclk);
        vsync_in = 1'b0;
        repeat (7) @(negedge pclk);
        run_until_fire(12, got_t, got_f, got_id);
        chk("post_reset_ticks", got_t, 8);
        chk("post_reset_fire", got_f, 5'b00010);
        chk("post_reset_id", got_id, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/enemy_fire_sched.md
ENEMY_FIRE_SCHED -- requirements
Module: enemy_fire_sched

Interface
REQ-001 Parameter FRAMES_BASE, default 60: frames between shots at level 1.
REQ-002 Parameter FRAMES_STEP, default 4: frames subtracted from the interval per level above 1.
REQ-003 Parameter FRAMES_MIN, default 8: floor on the shot interval.
REQ-004 Parameter MAX_INFLIGHT, default 3: maximum number of enemy missiles in flight at once.
REQ-005 Parameter HOLDOFF_FRAMES, default 120: frames of no firing after a level change.
REQ-006 pclk  in  1  single clock for the block; all logic is clocked by it.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 vsync_in  in  1  vertical sync; its rising edge marks a frame.
REQ-009 alive  in  5  bit i set = enemy i+1 has lives.
REQ-010 busy  in  5  bit i set = enemy i+1 missile in flight.
REQ-011 level_in  in  4  current level.
REQ-012 level_change  in  1  one-cycle level-up pulse.
REQ-013 fire  out  5  one-hot, one-cycle fire grant to enemy i+1.
REQ-014 fire_id  out  3  granted enemy number 1..5; 0 = no grant.
REQ-015 inflight  out  3  registered popcount of busy.
REQ-016 holdoff  out  1  high while in HOLDOFF.

Function
REQ-017 The block SHALL register vsync_in and generate tick for one cycle, in the cycle after a 0->1 edge is seen on the registered value.
REQ-018 The interval SHALL be max(FRAMES_MIN, FRAMES_BASE - FRAMES_STEP*(L-1)), with L = level_in, level_in=0 treated as 1, computed in 8 bits with saturation at 0 before the floor is applied.
REQ-019 The states SHALL be IDLE, SEARCH, GRANT and HOLDOFF, all encoded in registers.
REQ-020 In IDLE, the frame counter SHALL increment on each tick; the tick on which the counter equals interval-1 SHALL move the FSM to SEARCH and clear the counter.
REQ-021 In SEARCH, the block SHALL test one candidate per cycle, starting at ptr; the candidate is eligible when alive[ptr] & ~busy[ptr] & (inflight < MAX_INFLIGHT).
REQ-022 If the candidate is eligible, the FSM SHALL go to GRANT; otherwise ptr SHALL advance as (ptr+1) mod 5.
REQ-023 After 5 consecutive ineligible candidates, the FSM SHALL return to IDLE; the shot is dropped and the counter restarts from 0.
REQ-024 GRANT SHALL last one cycle, with fire[ptr]=1 and fire_id=ptr+1; ptr SHALL then advance as (ptr+1) mod 5 and the FSM SHALL return to IDLE.
REQ-025 Outside GRANT, fire SHALL be 0 and fire_id SHALL be 0.
REQ-026 fire SHALL never have more than one bit set.
REQ-027 level_change in any state SHALL force HOLDOFF on the next cycle, clear the counter and reset ptr to 0.
REQ-028 level_change coincident with a would-be grant SHALL win: no fire pulse is issued.
REQ-029 In HOLDOFF, the counter SHALL count ticks; on reaching HOLDOFF_FRAMES-1 with tick, the FSM SHALL go to IDLE and clear the counter.
REQ-030 level_change during HOLDOFF SHALL restart the holdoff count from 0.
REQ-031 inflight SHALL update one cycle after busy changes.
REQ-032 Eligibility in SEARCH SHALL use the registered inflight value.

Reset
REQ-033 While rst=1, the block SHALL hold the state IDLE, counter=0, ptr=0, fire=0, fire_id=0, inflight=0, holdoff=0, vsync register=0 and LFSR=5'b10101.
REQ-034 Reset asserted mid-SEARCH or mid-GRANT SHALL clear fire on the same edge, asynchronously.
REQ-035 No tick SHALL be generated on the first cycle after reset release when vsync_in is already high.

Configuration
REQ-036 With macro ENEMY_FIRE_SCHED_RANDOM_EN defined, a 5-bit Fibonacci LFSR (taps 5,3) SHALL step every cycle, and on entry to SEARCH ptr SHALL be loaded with LFSR mod 5.
REQ-037 Without ENEMY_FIRE_SCHED_RANDOM_EN, no LFSR SHALL be present and ptr SHALL follow pure round-robin continuation.
REQ-038 All other behaviour SHALL be identical with and without ENEMY_FIRE_SCHED_RANDOM_EN.

Verification
REQ-039 Scenario: level_in=1, alive=5'h1F, busy=0 -> the first fire pulse occurs after 60 ticks with fire=5'b00001 and fire_id=1; the next pulse occurs 60 ticks later with fire=5'b00010.
REQ-040 Scenario: level_in=3 -> the interval between pulses is 52 ticks; level_in=15 -> the interval is 8 ticks (floor).
REQ-041 Scenario: alive=5'b10100, ptr=0 -> SEARCH takes 3 cycles and the grant is fire_id=3; the next grant is fire_id=5.
REQ-042 Scenario: busy=5'b00111 (inflight=3), alive=5'h1F -> no fire pulse; the FSM returns to IDLE 5 cycles after entering SEARCH.
REQ-043 Scenario: level_change in the cycle a grant would start -> no pulse, holdoff=1 for 120 ticks, and the first subsequent grant is fire_id=1.
REQ-044 Scenario: rst pulsed during SEARCH -> all outputs are 0 immediately, and the first grant occurs a full interval after reset release.
